// File: rtl/sm_pool_reduce.sv
// sm_pool_reduce: streaming multi-lane min/max pooling reducer for
// sign-magnitude elements. Each lane folds a window of 1..WINDOW_MAX input
// beats into one result. One result beat is emitted per window. The output
// stage is a one-entry register, so the input accepts a beat whenever the
// result register is empty or is being consumed in the same cycle.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready input handshake; in_data lane i = [i*WIDTH +: WIDTH]
//   mode              0 = min, 1 = max (sampled on the first beat of a window)
//   window_len        beats per window (sampled on first beat; 0 -> 1,
//                     values above WINDOW_MAX clamp to WINDOW_MAX)
//   flush             drop the partial window (wins over a same-cycle beat)
//   out_valid/out_ready output handshake; out_data per-lane result,
//                     out_mode is the mode used for that result
//   busy              high while a partial window is being accumulated
//
// state | meaning
// EMPTY | no partial window; next accepted beat starts a window
// ACCUM | 1 <= count < len beats of the current window folded into acc
module sm_pool_reduce #(
  parameter int WIDTH      = 9,
  parameter int LANES      = 4,
  parameter int WINDOW_MAX = 16,
  parameter int CNT_W      = $clog2(WINDOW_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   mode,
  input  logic [CNT_W-1:0]       window_len,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   out_mode,
  output logic                   busy
);

  typedef enum logic {EMPTY, ACCUM} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [CNT_W-1:0]       len_q;
  logic                   mode_q;
  logic [LANES*WIDTH-1:0] acc_q;

  logic                   accept;
  logic                   first;
  logic                   done;
  logic [CNT_W-1:0]       eff_len_in;
  logic [CNT_W-1:0]       cur_len;
  logic                   cur_mode;
  logic [CNT_W-1:0]       count_inc;
  logic [LANES*WIDTH-1:0] acc_next;

  // Sign-magnitude "a < b": any negative is below any positive (so -0 < +0);
  // among negatives the larger magnitude is the smaller value.
  function automatic logic sm_lt(input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b);
    logic r;
    if (a[WIDTH-1] != b[WIDTH-1])
      r = a[WIDTH-1];
    else if (a[WIDTH-1])
      r = a[WIDTH-2:0] > b[WIDTH-2:0];
    else
      r = a[WIDTH-2:0] < b[WIDTH-2:0];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] sm_pick(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic             m);
    logic [WIDTH-1:0] r;
    if (m)
      r = sm_lt(a, b) ? b : a;
    else
      r = sm_lt(b, a) ? b : a;
    return r;
  endfunction

  // Depends only on the registered result, never on in_valid.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign first    = (state_q == EMPTY);
  assign busy     = (state_q == ACCUM);

  always_comb begin
    eff_len_in = window_len;
    if (window_len == '0)
      eff_len_in = CNT_W'(1);
    else if (window_len > CNT_W'(WINDOW_MAX))
      eff_len_in = CNT_W'(WINDOW_MAX);
  end

  assign cur_len   = first ? eff_len_in : len_q;
  assign cur_mode  = first ? mode : mode_q;
  assign count_inc = first ? CNT_W'(1) : count_q + CNT_W'(1);
  assign done      = accept && !flush && (count_inc == cur_len);

  always_comb begin
    acc_next = '0;
    for (int i = 0; i < LANES; i++) begin
      if (first)
        acc_next[i*WIDTH +: WIDTH] = in_data[i*WIDTH +: WIDTH];
      else
        acc_next[i*WIDTH +: WIDTH] = sm_pick(acc_q[i*WIDTH +: WIDTH],
                                             in_data[i*WIDTH +: WIDTH], mode_q);
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (flush) begin
      state_d = EMPTY;
      count_d = '0;
    end else if (accept) begin
      if (done) begin
        state_d = EMPTY;
        count_d = '0;
      end else begin
        state_d = ACCUM;
        count_d = count_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      len_q  <= CNT_W'(1);
      mode_q <= 1'b0;
    end else if (accept && !flush && !done) begin
      acc_q  <= acc_next;
      len_q  <= cur_len;
      mode_q <= cur_mode;
    end
  end

  // A completing beat may land in the same cycle the old result is consumed;
  // the new result then simply replaces it and out_valid stays high.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mode  <= 1'b0;
    end else if (done) begin
      out_valid <= 1'b1;
      out_data  <= acc_next;
      out_mode  <= cur_mode;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
